// File: rtl/regbank_pkg.sv
// Shared constants for the register-bank write scheduler: FSM encoding and
// default geometry of the dff_en bank.
package regbank_pkg;

   localparam int NREQ_DEF = 4;
   localparam int NREG_DEF = 8;
   localparam int W_DEF    = 8;
   localparam int AW_DEF   = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LATCH = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr, wrapping around. The pointer register is owned by the caller.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [PW-1:0]   idx
);

   logic found;

   // Scan priority positions ptr, ptr+1, ... and stop at the first active request.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
               found  = 1'b1;
               gnt[i] = 1'b1;
               idx    = PW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/regbank_wr_ctrl.sv
// Write scheduler for a dff_en register bank. One round-robin winner per
// 4-cycle transaction; wr_en is launched on the falling edge so the gated
// clock inside each dff_en sees a clean, full high phase.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for any req; captures winner, address and data
// ST_LATCH | drives captured data onto reg_wdata a full cycle before write
// ST_WRITE | decoded wr_en launched on the next negedge
// ST_ACK   | ack pulse to winner, rr pointer advances past winner
module regbank_wr_ctrl
   import regbank_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int NREG = NREG_DEF,
   parameter int W    = W_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*W-1:0]  req_data,
   output logic [NREQ-1:0]  ack,
   output logic [NREG-1:0]  reg_wr_en,
   output logic [W-1:0]     reg_wdata,
   output logic             busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]      state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   idx_q, idx_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [W-1:0]    data_q, data_d;
   logic [W-1:0]    wdata_q, wdata_d;
   logic [NREG-1:0] wr_en_q, wr_en_d;

   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   arb_idx;

   rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .req (req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   // Next-state, capture and pointer logic; inputs are only looked at in IDLE.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wdata_d = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               gnt_d   = arb_gnt;
               idx_d   = arb_idx;
               for (int i = 0; i < NREQ; i++) begin
                  if (arb_gnt[i]) begin
                     addr_d = req_addr[i*AW +: AW];
                     data_d = req_data[i*W +: W];
                  end
               end
               state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            wdata_d = data_q;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (int'(idx_q) >= NREQ - 1) ptr_d = '0;
            else                          ptr_d = idx_q + PW'(1);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Main rising-edge state and capture registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wdata_q <= wdata_d;
      end
   end

   // Address decode for the write enable, valid only while in WRITE.
   always_comb begin
      wr_en_d = '0;
      for (int r = 0; r < NREG; r++) begin
         if ((state_q == ST_WRITE) && (int'(addr_q) == r)) wr_en_d[r] = 1'b1;
      end
   end

   // wr_en gates the bank clock, so it may only change while clk is low.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) wr_en_q <= '0;
      else        wr_en_q <= wr_en_d;
   end

   assign ack       = (state_q == ST_ACK) ? gnt_q : '0;
   assign reg_wr_en = wr_en_q;
   assign reg_wdata = wdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regbank_wr_ctrl.sv
// Directed bench for regbank_wr_ctrl with a behavioural dff_en bank model.
module tb_regbank_wr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [11:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic [7:0]  reg_wr_en;
   logic [7:0]  reg_wdata;
   logic        busy;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int wr_phases   = 0;
   int glitches    = 0;
   logic [7:0] bank [8];

   regbank_wr_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .ack       (ack),
      .reg_wr_en (reg_wr_en),
      .reg_wdata (reg_wdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // dff_en bank: each register loads on the gated clock clk & wr_en
   always @(posedge clk) begin
      if (rst_n === 1'b1) begin
         if (reg_wr_en != 8'h00) wr_phases++;
         for (int r = 0; r < 8; r++)
            if (reg_wr_en[r]) bank[r] <= reg_wdata;
      end
   end

   always @(reg_wr_en) begin
      if (rst_n === 1'b1 && clk === 1'b1) begin
         glitches++;
         $display("FAIL glitch: reg_wr_en changed to %b while clk=1 at %0t", reg_wr_en, $time);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
      req[i] = 1'b1;
      req_addr[i*3 +: 3] = a;
      req_data[i*8 +: 8] = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_ack(input int maxc, output logic [3:0] got);
      logic done;
      got  = '0;
      done = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (!done) begin
            tick();
            if (ack != 4'b0) begin
               got  = ack;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0;
      #3;
      vectors++;
      if ({ack, reg_wr_en, reg_wdata, busy} !== 21'b0) begin
         miscompares++;
         $display("FAIL reset_init: ack=%b wr_en=%b wdata=%h busy=%b, expected all 0", ack, reg_wr_en, reg_wdata, busy);
      end
      @(negedge clk); #2 rst_n = 1'b1;
      set_req(1, 3'd2, 8'h3C);
      tick(); tick(); tick();
      vectors++;
      if (ack !== 4'b0010 || reg_wdata !== 8'h3C) begin
         miscompares++;
         $display("FAIL reset_pre: ack=%b wdata=%h, expected 0010 3c", ack, reg_wdata);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({ack, reg_wr_en, reg_wdata, busy} !== 21'b0 || clk !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_async: ack=%b wr_en=%b wdata=%h busy=%b clk=%b, expected all 0 with clk=1", ack, reg_wr_en, reg_wdata, busy, clk);
      end
      req = '0;
      @(negedge clk); #2 rst_n = 1'b1;
   endtask

   task automatic test_single();
      set_req(2, 3'd5, 8'hA5);
      tick();
      vectors++;
      if (busy !== 1'b1 || reg_wr_en !== 8'h00) begin
         miscompares++;
         $display("FAIL single_latch: busy=%b wr_en=%b, expected 1 00000000", busy, reg_wr_en);
      end
      tick();
      vectors++;
      if (reg_wdata !== 8'hA5 || reg_wr_en !== 8'h00) begin
         miscompares++;
         $display("FAIL single_wdata: wdata=%h wr_en=%b, expected a5 00000000", reg_wdata, reg_wr_en);
      end
      @(negedge clk); #1;
      vectors++;
      if (reg_wr_en !== 8'b0010_0000) begin
         miscompares++;
         $display("FAIL single_wren_rise: wr_en=%b, expected 00100000", reg_wr_en);
      end
      tick();
      vectors++;
      if (reg_wr_en !== 8'b0010_0000 || ack !== 4'b0100 || bank[5] !== 8'hA5) begin
         miscompares++;
         $display("FAIL single_write: wr_en=%b ack=%b reg5=%h, expected 00100000 0100 a5", reg_wr_en, ack, bank[5]);
      end
      req = '0;
      @(negedge clk); #1;
      vectors++;
      if (reg_wr_en !== 8'h00) begin
         miscompares++;
         $display("FAIL single_wren_fall: wr_en=%b, expected 00000000", reg_wr_en);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || ack !== 4'b0 || reg_wdata !== 8'hA5) begin
         miscompares++;
         $display("FAIL single_done: busy=%b ack=%b wdata=%h, expected 0 0000 a5", busy, ack, reg_wdata);
      end
   endtask

   task automatic test_contention();
      logic [3:0] got;
      logic [3:0] exp;
      int last;
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 3'(i + 4), 8'(8'hC0 + i));
      last = 0;
      for (int k = 0; k < 5; k++) begin
         wait_ack(8, got);
         exp = 4'(1 << (k % 4));
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL contention_order[%0d]: ack=%b, expected %b", k, got, exp);
         end
         if (k > 0) begin
            vectors++;
            if (cyc - last !== 4) begin
               miscompares++;
               $display("FAIL contention_spacing[%0d]: %0d cycles, expected 4", k, cyc - last);
            end
         end
         last = cyc;
      end
      req = '0;
      tick();
      vectors++;
      if (bank[4] !== 8'hC0 || bank[5] !== 8'hC1 || bank[6] !== 8'hC2 || bank[7] !== 8'hC3) begin
         miscompares++;
         $display("FAIL contention_data: reg4..7=%h %h %h %h, expected c0 c1 c2 c3", bank[4], bank[5], bank[6], bank[7]);
      end
   endtask

   task automatic test_glitch();
      logic [3:0] got;
      int ph0;
      ph0 = wr_phases;
      set_req(1, 3'd0, 8'h99);
      wait_ack(8, got);
      req = '0;
      tick();
      vectors++;
      if (got !== 4'b0010 || bank[0] !== 8'h99) begin
         miscompares++;
         $display("FAIL glitch_write: ack=%b reg0=%h, expected 0010 99", got, bank[0]);
      end
      vectors++;
      if (wr_phases - ph0 !== 1 || glitches !== 0) begin
         miscompares++;
         $display("FAIL glitch_phases: high phases=%0d toggles_high=%0d, expected 1 0", wr_phases - ph0, glitches);
      end
   endtask

   task automatic test_reset_in_write();
      logic [3:0] got;
      logic seen_ack;
      set_req(3, 3'd1, 8'h77);
      tick(); tick();
      @(negedge clk); #1;
      vectors++;
      if (reg_wr_en !== 8'b0000_0010) begin
         miscompares++;
         $display("FAIL rstwr_pre: wr_en=%b, expected 00000010", reg_wr_en);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (reg_wr_en !== 8'h00 || busy !== 1'b0 || ack !== 4'b0) begin
         miscompares++;
         $display("FAIL rstwr_async: wr_en=%b busy=%b ack=%b, expected 00000000 0 0000", reg_wr_en, busy, ack);
      end
      seen_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (ack != 4'b0) seen_ack = 1'b1;
      end
      vectors++;
      if (seen_ack !== 1'b0) begin
         miscompares++;
         $display("FAIL rstwr_noack: ack seen=%b, expected 0", seen_ack);
      end
      @(negedge clk); #2 rst_n = 1'b1;
      wait_ack(8, got);
      req = '0;
      tick();
      vectors++;
      if (got !== 4'b1000 || bank[1] !== 8'h77) begin
         miscompares++;
         $display("FAIL rstwr_retry: ack=%b reg1=%h, expected 1000 77", got, bank[1]);
      end
   endtask

   task automatic test_same_addr();
      logic [3:0] got;
      do_reset();
      set_req(0, 3'd3, 8'h11);
      set_req(1, 3'd3, 8'h22);
      wait_ack(8, got);
      req[0] = 1'b0;
      vectors++;
      if (got !== 4'b0001 || bank[3] !== 8'h11) begin
         miscompares++;
         $display("FAIL same_first: ack=%b reg3=%h, expected 0001 11", got, bank[3]);
      end
      wait_ack(8, got);
      req[1] = 1'b0;
      vectors++;
      if (got !== 4'b0010 || bank[3] !== 8'h22) begin
         miscompares++;
         $display("FAIL same_last: ack=%b reg3=%h, expected 0010 22", got, bank[3]);
      end
      tick();
   endtask

   task automatic test_drop_after_capture();
      logic [3:0] got;
      set_req(2, 3'd6, 8'h5A);
      tick();
      req = '0;
      wait_ack(8, got);
      vectors++;
      if (got !== 4'b0100 || bank[6] !== 8'h5A) begin
         miscompares++;
         $display("FAIL drop_capture: ack=%b reg6=%h, expected 0100 5a", got, bank[6]);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_glitch();
      test_reset_in_write();
      test_same_addr();
      test_drop_after_capture();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
